// File: rtl/timer_scheduler_if.sv
// Request/programming bus between the top-level FSMs and timer_scheduler.
// Also carries the shared 1 Hz / 0.5 Hz enables back out.
interface timer_scheduler_if;
    logic [2:0] req;
    logic [2:0] cancel;
    logic [5:0] interval_id;
    logic       prog_en;
    logic [1:0] prog_sel;
    logic [3:0] prog_value;
    logic [2:0] grant;
    logic [2:0] expired;
    logic [2:0] aborted;
    logic       busy;
    logic [3:0] remaining;
    logic       one_hz_enable;
    logic       half_hz_enable;

    modport master (
        output req, cancel, interval_id,
        output prog_en, prog_sel, prog_value,
        input  grant, expired, aborted, busy,
        input  remaining, one_hz_enable, half_hz_enable
    );

    modport slave (
        input  req, cancel, interval_id,
        input  prog_en, prog_sel, prog_value,
        output grant, expired, aborted, busy,
        output remaining, one_hz_enable, half_hz_enable
    );
endinterface

// File: rtl/timer_scheduler.sv
// Shared countdown timer: fixed-priority arbitration with preemption,
// programmable interval table, and 1 Hz / 0.5 Hz enable generation.
module timer_scheduler #(
    parameter int CLK_HZ = 100000000,
    parameter int T0_DEF = 6,
    parameter int T1_DEF = 8,
    parameter int T2_DEF = 15,
    parameter int T3_DEF = 10
) (
    input logic clock,
    input logic reset,
    timer_scheduler_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COUNT,
        EXPIRE
    } state_t;

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int HW = $clog2(2 * CLK_HZ);
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_HZ - 1);
    localparam logic [HW-1:0] HALF_LAST = HW'(2 * CLK_HZ - 1);

    state_t     state;
    logic [1:0] owner;
    logic [2:0] pending;
    logic [3:0] table_q [4];
    logic [2:0] grant_q;
    logic [2:0] expired_q;
    logic [2:0] aborted_q;
    logic       busy_q;
    logic [3:0] remaining_q;
    logic [PW-1:0] pre_q;
    logic [HW-1:0] half_q;

    logic       one_hz;
    logic [2:0] first;
    logic [1:0] top_idx;
    logic       top_valid;
    logic       preempt;
    logic       cancel_own;
    logic [1:0] entry;
    logic [3:0] load_val;
    logic [2:0] clr_mask;

    assign one_hz = (pre_q == PRE_LAST);

    // Isolate the lowest set bit so the decoder sees a one-hot value.
    assign first = pending & (~pending + 3'd1);

    always_comb begin
        top_idx   = 2'd0;
        top_valid = 1'b1;
        unique case (1'b1)
            first[0]: top_idx = 2'd0;
            first[1]: top_idx = 2'd1;
            first[2]: top_idx = 2'd2;
            default:  top_valid = 1'b0;
        endcase
    end

    assign preempt    = top_valid && (top_idx < owner);
    assign cancel_own = |(bus.cancel & grant_q);
    assign entry      = bus.interval_id[{owner, 1'b0} +: 2];
    assign load_val   = table_q[entry];

    always_comb begin
        clr_mask = '0;
        if (state == LOAD || (state == COUNT && preempt))
            clr_mask = grant_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            owner       <= '0;
            pending     <= '0;
            grant_q     <= '0;
            expired_q   <= '0;
            aborted_q   <= '0;
            busy_q      <= 1'b0;
            remaining_q <= '0;
            table_q[0]  <= 4'(T0_DEF);
            table_q[1]  <= 4'(T1_DEF);
            table_q[2]  <= 4'(T2_DEF);
            table_q[3]  <= 4'(T3_DEF);
        end else begin
            expired_q <= '0;
            aborted_q <= '0;
            pending   <= (pending | bus.req) & ~bus.cancel & ~clr_mask;
            if (bus.prog_en)
                table_q[bus.prog_sel] <= bus.prog_value;
            unique case (state)
                IDLE: begin
                    if (top_valid) begin
                        owner   <= top_idx;
                        grant_q <= first;
                        busy_q  <= 1'b1;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    if (cancel_own) begin
                        grant_q     <= '0;
                        remaining_q <= '0;
                        busy_q      <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        remaining_q <= load_val;
                        state <= (load_val == 4'd0) ? EXPIRE : COUNT;
                    end
                end
                COUNT: begin
                    if (cancel_own) begin
                        grant_q     <= '0;
                        remaining_q <= '0;
                        busy_q      <= 1'b0;
                        state       <= IDLE;
                    end else if (preempt) begin
                        aborted_q <= grant_q;
                        grant_q   <= first;
                        owner     <= top_idx;
                        state     <= LOAD;
                    end else if (|(pending & grant_q)) begin
                        state <= LOAD;
                    end else if (one_hz) begin
                        if (remaining_q == 4'd1) begin
                            remaining_q <= '0;
                            state       <= EXPIRE;
                        end else begin
                            remaining_q <= remaining_q - 4'd1;
                        end
                    end
                end
                EXPIRE: begin
                    expired_q   <= grant_q;
                    grant_q     <= '0;
                    remaining_q <= '0;
                    busy_q      <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Second prescaler restarts at LOAD so the first counted second is full.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pre_q  <= '0;
            half_q <= '0;
        end else begin
            if (state == LOAD || one_hz)
                pre_q <= '0;
            else
                pre_q <= pre_q + 1'b1;
            if (half_q == HALF_LAST)
                half_q <= '0;
            else
                half_q <= half_q + 1'b1;
        end
    end

    assign bus.grant          = grant_q;
    assign bus.expired        = expired_q;
    assign bus.aborted        = aborted_q;
    assign bus.busy           = busy_q;
    assign bus.remaining      = remaining_q;
    assign bus.one_hz_enable  = one_hz;
    assign bus.half_hz_enable = (half_q == HALF_LAST);

endmodule

// File: tb/tb_timer_scheduler.sv
// Directed table-driven bench for timer_scheduler at CLK_HZ=10.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_timer_scheduler;

    typedef struct {
        logic [2:0] req;
        logic [2:0] cancel;
        logic       pe;
        logic [1:0] ps;
        logic [3:0] pv;
        int         wait_n;
        logic [2:0] grant;
        logic [3:0] rem;
        logic       busy;
        logic [2:0] expd;
        logic [2:0] abrt;
    } vec_t;

    localparam int NV = 37;

    logic clock;
    logic reset;
    int   checks;
    int   errors;
    int   exp_cnt [3];
    int   abt_cnt [3];
    vec_t vecs [NV];
    int   defs [4];

    timer_scheduler_if bus ();

    timer_scheduler #(.CLK_HZ(10)) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (!reset) begin
            for (int b = 0; b < 3; b++) begin
                if (bus.expired[b]) exp_cnt[b] = exp_cnt[b] + 1;
                if (bus.aborted[b]) abt_cnt[b] = abt_cnt[b] + 1;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        clock  = 1'b0;
        reset  = 1'b1;
        checks = 0;
        errors = 0;
        for (int b = 0; b < 3; b++) begin
            exp_cnt[b] = 0;
            abt_cnt[b] = 0;
        end
        defs[0] = 6; defs[1] = 8; defs[2] = 15; defs[3] = 10;
        bus.req         = '0;
        bus.cancel      = '0;
        bus.interval_id = 6'b11_00_01;
        bus.prog_en     = 1'b0;
        bus.prog_sel    = '0;
        bus.prog_value  = '0;

        // req, cancel, pe, ps, pv, wait, grant, rem, busy, exp, abt
        vecs[0]  = '{3'b010, 0, 0, 0, 0,  1, 3'b010, 0, 1, 0, 0};
        vecs[1]  = '{3'b000, 0, 0, 0, 0,  0, 3'b010, 6, 1, 0, 0};
        vecs[2]  = '{3'b000, 0, 0, 0, 0,  9, 3'b010, 5, 1, 0, 0};
        vecs[3]  = '{3'b000, 0, 0, 0, 0, 49, 3'b010, 0, 1, 0, 0};
        vecs[4]  = '{3'b000, 0, 0, 0, 0,  0, 3'b000, 0, 0, 3'b010, 0};
        vecs[5]  = '{3'b000, 0, 0, 0, 0,  0, 3'b000, 0, 0, 0, 0};
        vecs[6]  = '{3'b100, 0, 0, 0, 0,  1, 3'b100, 0, 1, 0, 0};
        vecs[7]  = '{3'b000, 0, 0, 0, 0,  0, 3'b100, 10, 1, 0, 0};
        vecs[8]  = '{3'b000, 0, 0, 0, 0, 59, 3'b100, 4, 1, 0, 0};
        vecs[9]  = '{3'b001, 0, 0, 0, 0,  0, 3'b100, 4, 1, 0, 0};
        vecs[10] = '{3'b000, 0, 0, 0, 0,  0, 3'b001, 4, 1, 0, 3'b100};
        vecs[11] = '{3'b000, 0, 0, 0, 0,  0, 3'b001, 8, 1, 0, 0};
        vecs[12] = '{3'b000, 0, 0, 0, 0, 80, 3'b000, 0, 0, 3'b001, 0};
        vecs[13] = '{3'b010, 0, 0, 0, 0,  1, 3'b010, 0, 1, 0, 0};
        vecs[14] = '{3'b000, 0, 0, 0, 0,  0, 3'b010, 6, 1, 0, 0};
        vecs[15] = '{3'b000, 0, 0, 0, 0, 29, 3'b010, 3, 1, 0, 0};
        vecs[16] = '{3'b000, 3'b010, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0};
        vecs[17] = '{3'b001, 3'b001, 0, 0, 0, 2, 3'b000, 0, 0, 0, 0};
        vecs[18] = '{3'b100, 0, 0, 0, 0,  1, 3'b100, 0, 1, 0, 0};
        vecs[19] = '{3'b000, 0, 0, 0, 0,  0, 3'b100, 10, 1, 0, 0};
        vecs[20] = '{3'b000, 0, 1, 3, 2,  8, 3'b100, 10, 1, 0, 0};
        vecs[21] = '{3'b000, 0, 0, 0, 0,  0, 3'b100, 9, 1, 0, 0};
        vecs[22] = '{3'b000, 0, 0, 0, 0, 90, 3'b000, 0, 0, 3'b100, 0};
        vecs[23] = '{3'b100, 0, 0, 0, 0,  1, 3'b100, 0, 1, 0, 0};
        vecs[24] = '{3'b000, 0, 0, 0, 0,  0, 3'b100, 2, 1, 0, 0};
        vecs[25] = '{3'b000, 0, 0, 0, 0, 20, 3'b000, 0, 0, 3'b100, 0};
        vecs[26] = '{3'b000, 0, 1, 0, 0,  0, 3'b000, 0, 0, 0, 0};
        vecs[27] = '{3'b010, 0, 0, 0, 0,  1, 3'b010, 0, 1, 0, 0};
        vecs[28] = '{3'b000, 0, 0, 0, 0,  0, 3'b010, 0, 1, 0, 0};
        vecs[29] = '{3'b000, 0, 0, 0, 0,  0, 3'b000, 0, 0, 3'b010, 0};
        vecs[30] = '{3'b100, 0, 0, 0, 0,  1, 3'b100, 0, 1, 0, 0};
        vecs[31] = '{3'b000, 0, 0, 0, 0,  0, 3'b100, 2, 1, 0, 0};
        vecs[32] = '{3'b000, 0, 0, 0, 0,  9, 3'b100, 1, 1, 0, 0};
        vecs[33] = '{3'b100, 0, 0, 0, 0,  0, 3'b100, 1, 1, 0, 0};
        vecs[34] = '{3'b000, 0, 0, 0, 0,  0, 3'b100, 1, 1, 0, 0};
        vecs[35] = '{3'b000, 0, 0, 0, 0,  0, 3'b100, 2, 1, 0, 0};
        vecs[36] = '{3'b000, 0, 0, 0, 0, 20, 3'b000, 0, 0, 3'b100, 0};

        repeat (2) @(negedge clock);
        check("reset grant", int'(bus.grant), 0);
        check("reset busy", int'(bus.busy), 0);
        check("reset remaining", int'(bus.remaining), 0);
        reset = 1'b0;
        @(negedge clock);

        for (int i = 0; i < NV; i++) begin
            bus.req        = vecs[i].req;
            bus.cancel     = vecs[i].cancel;
            bus.prog_en    = vecs[i].pe;
            bus.prog_sel   = vecs[i].ps;
            bus.prog_value = vecs[i].pv;
            @(negedge clock);
            bus.req     = '0;
            bus.cancel  = '0;
            bus.prog_en = 1'b0;
            repeat (vecs[i].wait_n) @(negedge clock);
            check($sformatf("row%0d grant", i),
                  int'(bus.grant), int'(vecs[i].grant));
            check($sformatf("row%0d remaining", i),
                  int'(bus.remaining), int'(vecs[i].rem));
            check($sformatf("row%0d busy", i),
                  int'(bus.busy), int'(vecs[i].busy));
            check($sformatf("row%0d expired", i),
                  int'(bus.expired), int'(vecs[i].expd));
            check($sformatf("row%0d aborted", i),
                  int'(bus.aborted), int'(vecs[i].abrt));
        end

        // Reset in the middle of a 15 s count once it reaches 5.
        bus.interval_id = 6'b00_10_00;
        bus.req = 3'b010;
        @(negedge clock);
        bus.req = '0;
        repeat (102) @(negedge clock);
        check("pre-reset remaining", int'(bus.remaining), 5);
        reset = 1'b1;
        #1;
        check("async reset outputs",
              int'({bus.grant, bus.expired, bus.aborted, bus.busy,
                    bus.remaining, bus.one_hz_enable,
                    bus.half_hz_enable}), 0);
        @(negedge clock);
        reset = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            check($sformatf("half_hz k=%0d", k),
                  int'(bus.half_hz_enable), (k % 20 == 19) ? 1 : 0);
        end

        for (int e = 0; e < 4; e++) begin
            bus.interval_id = {4'b0000, 2'(e)};
            bus.req = 3'b001;
            @(negedge clock);
            bus.req = '0;
            repeat (2) @(negedge clock);
            check($sformatf("default entry %0d", e),
                  int'(bus.remaining), defs[e]);
            bus.cancel = 3'b001;
            @(negedge clock);
            bus.cancel = '0;
        end

        check("expired[0] pulses", exp_cnt[0], 1);
        check("expired[1] pulses", exp_cnt[1], 2);
        check("expired[2] pulses", exp_cnt[2], 3);
        check("aborted[0] pulses", abt_cnt[0], 0);
        check("aborted[1] pulses", abt_cnt[1], 0);
        check("aborted[2] pulses", abt_cnt[2], 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/timer_scheduler.md
Name: timer_scheduler

Overview:
- Owns the single countdown timer and shares it between three requesters: 0 = alarm FSM trigger/stop delays, 1 = arming FSM arm delay, 2 = siren-on duration.
- Holds the programmable 4-entry interval table, selects one owner by fixed priority with preemption, and counts down in seconds.
- Returns a one-cycle expired pulse to the owner and produces the 1 Hz and 0.5 Hz enables for the display and siren drivers.
- Sits between the top-level FSMs and the siren_generator and display drivers.

Parameters:
- CLK_HZ, 100000000, clock cycles per second.
- T0_DEF, 6, reset value of table entry 0 (arm delay, s).
- T1_DEF, 8, reset value of table entry 1 (driver door delay, s).
- T2_DEF, 15, reset value of table entry 2 (passenger door delay, s).
- T3_DEF, 10, reset value of table entry 3 (alarm-on duration, s).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  3  per-requester start/restart pulse.
- cancel  in  3  per-requester withdraw.
- interval_id  in  6  table index per requester; [2i+1:2i] belongs to requester i.
- prog_en  in  1  write table entry this cycle.
- prog_sel  in  2  table entry to write.
- prog_value  in  4  value to write, in seconds.
- grant  out  3  one-hot current owner; 0 when idle.
- expired  out  3  one-cycle pulse to the owner whose count finished.
- aborted  out  3  one-cycle pulse to an owner that was preempted.
- busy  out  1  high in LOAD, COUNT or EXPIRE.
- remaining  out  4  seconds left for the current owner; 0 when idle.
- one_hz_enable  out  1  one-cycle pulse each second of the countdown prescaler.
- half_hz_enable  out  1  one-cycle pulse every 2 s, free-running.

Behaviour:
- Clocking and reset
  - Single clock. Asynchronous active-high reset clears pending, grant, expired, aborted, busy, remaining, both prescalers and the state (to IDLE).
  - Reset loads the table with T0_DEF..T3_DEF.
  - Reset mid-count drops the owner silently: no expired, no aborted.
- Pending
  - pending[i] is set on the clock edge where req[i] is high.
  - pending[i] is cleared when i is served (LOAD), cancelled, or preempted.
  - req[i] and cancel[i] in the same cycle: cancel wins and pending[i] ends at 0.
- Priority: fixed, lowest index wins.
- State machine: IDLE, LOAD, COUNT, EXPIRE.
  - IDLE: if pending is nonzero, grant the highest-priority pending requester and go to LOAD on the next edge.
  - LOAD (1 cycle): remaining = table[interval_id of owner], clear the 1 Hz prescaler, clear pending[owner]. If the loaded value is 0, go to EXPIRE; otherwise go to COUNT.
  - COUNT: on one_hz_enable, if remaining==1 go to EXPIRE with remaining=0; otherwise decrement remaining.
  - EXPIRE (1 cycle): expired[owner]=1, then grant=0, remaining=0, return to IDLE.
  - Latency from req to the expired pulse for value N≥1 is N*CLK_HZ + 3 cycles (+/-1 for the req sampling edge).
- Preemption in COUNT
  - If pending holds an index lower than the owner, pulse aborted[owner] for one cycle, move grant to the new owner, and go to LOAD.
  - The old owner is not re-queued.
- Restart and cancel in COUNT
  - req from the current owner restarts the count: go to LOAD, no aborted pulse.
  - cancel[owner] in LOAD or COUNT: go to IDLE, grant=0, remaining=0, no expired and no aborted.
  - A cancel arriving in EXPIRE is too late: the expired pulse still fires.
- Table programming
  - A write takes effect on the edge after prog_en.
  - It never alters a running count; the new value is used at the next LOAD.
  - A write in the same cycle as LOAD loads the old value.
- Prescalers
  - The 1 Hz prescaler counts 0..CLK_HZ-1 and pulses at CLK_HZ-1. It runs in every state and is cleared only at LOAD and reset, so the first counted second is always full.
  - half_hz_enable comes from an independent 0..2*CLK_HZ-1 counter that is never cleared except by reset.
- Width: remaining is 4 bits, so the maximum interval is 15 s. No wrap is possible because a count never decrements past 1.

Test Plan:
- Basic: CLK_HZ=10, reset, req[1] with interval_id[3:2]=0 → grant=010 two cycles later, remaining=6, expired[1] one-cycle pulse after 60 more cycles, then grant=000 and remaining=0.
- Preemption: req[2] counting a 10 s interval, at remaining=4 pulse req[0] with table entry 1 → aborted[2] pulse, grant=001, remaining=8, expired[0] only; expired[2] never pulses.
- Cancel: req[1], then cancel[1] while remaining=3 → grant=000, busy=0, no expired. Also req[0] and cancel[0] in the same cycle → nothing granted.
- Reprogram: write entry 3=2 while requester 2 counts entry 3 at default 10 → current run lasts 10 s; the next req[2] gives remaining=2 and expires after 2 s.
- Zero/restart: program entry 0=0 and req[1] → expired[1] two cycles after LOAD. req[2] re-pulsed at remaining=1 → remaining reloads to the full value, no aborted pulse.
- Reset mid-count at remaining=5 → all outputs 0 immediately, table back to 6/8/15/10; half_hz_enable pulses every 20 cycles from release.
